// File: rtl/clint_timer.sv
// Machine timer (mtime/mtimecmp) on a simple sel/we/ack peripheral bus.
// Drives a registered level interrupt when mtime >= mtimecmp.
module clint_timer #(
  parameter int DIV_W  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              timer_int
);

  localparam logic [ADDR_W-3:0] OFF_MTIME_LO = 'd0;
  localparam logic [ADDR_W-3:0] OFF_MTIME_HI = 'd1;
  localparam logic [ADDR_W-3:0] OFF_CMP_LO   = 'd2;
  localparam logic [ADDR_W-3:0] OFF_CMP_HI   = 'd3;
  localparam logic [ADDR_W-3:0] OFF_CTRL     = 'd4;

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic             en_q, en_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [31:0]      snap_q, snap_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ack_q, ack_d;
  logic             timer_int_q, timer_int_d;

  logic             accept, wr_en, rd_en, tick;
  logic [ADDR_W-3:0] word;
  logic [31:0]      ctrl_rd;
  logic             unused_addr;

  // Byte lane bits carry no meaning in a word-only register window.
  assign unused_addr = ^addr[1:0];
  assign word        = addr[ADDR_W-1:2];

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[0]           = en_q;
    ctrl_rd[16 +: DIV_W] = div_q;
  end

  always_comb begin
    accept = sel && !ack_q;
    wr_en  = accept && we;
    rd_en  = accept && !we;
    // Tick uses the configuration in force before this edge, even on a CTRL write.
    tick   = en_q && (presc_q == div_q);

    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    en_d        = en_q;
    div_d       = div_q;
    snap_d      = snap_q;
    rdata_d     = '0;
    ack_d       = accept;
    timer_int_d = (mtime_q >= mtimecmp_q);

    if (!en_q || tick) presc_d = '0;
    else               presc_d = presc_q + 1'b1;

    if (tick) mtime_d = mtime_q + 64'd1;

    // A write to either mtime half overrides (and drops) a same-edge increment.
    if (wr_en) begin
      case (word)
        OFF_MTIME_LO: mtime_d = {mtime_q[63:32], wdata};
        OFF_MTIME_HI: mtime_d = {wdata, mtime_q[31:0]};
        OFF_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], wdata};
        OFF_CMP_HI:   mtimecmp_d = {wdata, mtimecmp_q[31:0]};
        OFF_CTRL: begin
          en_d    = wdata[0];
          div_d   = wdata[16 +: DIV_W];
          presc_d = '0;
        end
        default: ;
      endcase
    end

    if (rd_en) begin
      case (word)
        OFF_MTIME_LO: begin
          rdata_d = mtime_q[31:0];
          snap_d  = mtime_q[63:32];
        end
        OFF_MTIME_HI: rdata_d = snap_q;
        OFF_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        OFF_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        OFF_CTRL:     rdata_d = ctrl_rd;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      en_q        <= 1'b0;
      div_q       <= '0;
      presc_q     <= '0;
      snap_q      <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      en_q        <= en_d;
      div_q       <= div_d;
      presc_q     <= presc_d;
      snap_q      <= snap_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign timer_int = timer_int_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: read data checked by a scoreboard on each ack,
// timing-sensitive levels checked inline.
module tb_clint_timer;

  logic        clk;
  logic        reset_n;
  logic        sel;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        timer_int;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] exp;
    string       tag;
  } sb_t;
  sb_t sb[$];

  localparam logic [4:0] A_LO   = 5'h00;
  localparam logic [4:0] A_HI   = 5'h04;
  localparam logic [4:0] A_CLO  = 5'h08;
  localparam logic [4:0] A_CHI  = 5'h0C;
  localparam logic [4:0] A_CTRL = 5'h10;

  clint_timer #(.DIV_W(16), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ack       (ack),
    .timer_int (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ack pops the oldest expectation and compares rdata.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_ack got=%h exp=none", rdata);
      end
      if (sb.size() != 0) begin
        sb_t e;
        e = sb.pop_front();
        chk(e.tag, rdata, e.exp);
      end
    end
  end

  // Called at a negedge: drive a request and queue the expected read data.
  task automatic bus_req(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] e, input string tag);
    sb_t s;
    sel   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    s.exp = w ? 32'h0 : e;
    s.tag = tag;
    sb.push_back(s);
  endtask

  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] e, input string tag);
    bus_req(w, a, d, e, tag);
    @(negedge clk);
    chk({tag, "_ack"}, 32'(ack), 32'd1);
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 32'h0, "wr");
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string tag);
    bus(1'b0, a, 32'h0, e, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    sel     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Reset state
    chk("rst_int", 32'(timer_int), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rd(A_LO, 32'h0, "rst_mtime_lo");
    rd(A_CHI, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(A_CLO, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(A_CTRL, 32'h0, "rst_ctrl");

    // Compare at 20, DIV=0: mtime==i after the i-th edge past the CTRL write
    wr(A_CHI, 32'h0);
    wr(A_CLO, 32'd20);
    wr(A_CTRL, 32'h0000_0001);
    for (int i = 2; i <= 24; i++) begin
      @(negedge clk);
      chk("int_rise", 32'(timer_int), 32'(i >= 21));
    end
    bus_req(1'b1, A_CLO, 32'd100, 32'h0, "cmp100");
    @(negedge clk);
    chk("cmp100_ack", 32'(ack), 32'd1);
    chk("int_hold", 32'(timer_int), 32'd1);
    sel = 1'b0;
    @(negedge clk);
    chk("int_drop", 32'(timer_int), 32'd0);

    // DIV=3 from mtime=0: reads every 2 cycles see 0,0,1,1,2,2
    wr(A_CTRL, 32'h0);
    wr(A_LO, 32'h0);
    wr(A_HI, 32'h0);
    wr(A_CTRL, 32'h0003_0001);
    for (int k = 1; k <= 6; k++) rd(A_LO, 32'((2 * k - 1) / 4), "div3");
    wr(A_CTRL, 32'h0003_0000);
    repeat (10) @(negedge clk);
    rd(A_LO, 32'd3, "frozen");
    wr(A_CTRL, 32'h0003_0001);
    rd(A_LO, 32'd3, "resume0");
    rd(A_LO, 32'd3, "resume1");
    rd(A_LO, 32'd4, "resume2");

    // Carry into the high word and hi snapshot
    wr(A_CTRL, 32'h0);
    wr(A_HI, 32'h0);
    wr(A_LO, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'h0000_0001);
    @(negedge clk);
    rd(A_LO, 32'h0, "carry_lo");
    rd(A_HI, 32'h1, "carry_hi");
    chk("int_64b", 32'(timer_int), 32'd1);
    repeat (5) @(negedge clk);
    rd(A_HI, 32'h1, "snap_hold");
    wr(A_HI, 32'h7);
    rd(A_HI, 32'h1, "snap_stale");
    rd(A_LO, 32'hE, "hi_wr_drop");
    rd(A_HI, 32'h7, "snap_new");

    // Write MTIME_LO on a tick edge (DIV=0 ticks every edge)
    wr(A_LO, 32'h500);
    rd(A_LO, 32'h501, "tick_wr");
    rd(A_LO, 32'h503, "tick_next");

    // 64-bit wrap
    wr(A_CTRL, 32'h0);
    wr(A_HI, 32'hFFFF_FFFF);
    wr(A_LO, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h0000_0001);
    rd(A_LO, 32'h0, "wrap_lo");
    rd(A_HI, 32'h0, "wrap_hi");
    chk("wrap_int", 32'(timer_int), 32'd0);

    // sel held for 6 edges: acks after edges 1, 3, 5
    for (int k = 0; k < 3; k++) begin
      sb_t s;
      s.exp = 32'd100;
      s.tag = "b2b";
      sb.push_back(s);
    end
    sel  = 1'b1;
    we   = 1'b0;
    addr = A_CLO;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("b2b_ack", 32'(ack), 32'(k % 2));
    end
    sel = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 32'(ack), 32'd0);

    // Unmapped offsets
    rd(5'h14, 32'h0, "off14_rd");
    bus(1'b1, 5'h14, 32'hFFFF_FFFF, 32'h0, "off14_wr");
    rd(A_CTRL, 32'h0000_0001, "ctrl_intact");
    rd(5'h1C, 32'h0, "off1c_rd");

    // Reset while ack is high
    bus_req(1'b0, A_CLO, 32'h0, 32'd100, "mid_rst");
    @(negedge clk);
    chk("mid_ack", 32'(ack), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_ack_drop", 32'(ack), 32'd0);
    chk("mid_rdata", rdata, 32'd0);
    chk("mid_int", 32'(timer_int), 32'd0);
    sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(A_CHI, 32'hFFFF_FFFF, "post_cmp_hi");
    rd(A_CLO, 32'hFFFF_FFFF, "post_cmp_lo");
    rd(A_LO, 32'h0, "post_mtime_lo");
    rd(A_HI, 32'h0, "post_snap");
    rd(A_CTRL, 32'h0, "post_ctrl");
    chk("post_int", 32'(timer_int), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
